fifo_rd_ctrl: RTL

- Read-side controller of the asynchronous FIFO. It is the reader paired with the write-side pointer logic.
- Takes the Gray-coded write pointer from the write clock domain and synchronises it into clk.
- Converts that pointer to binary, computes empty and occupancy, and owns the read pointer.
- Drives the dual-port memory read address and presents data through a first-word-fall-through output register with a valid/ready handshake.

---
 rtl/fifo_rd_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO.
// It synchronises the Gray write pointer into clk and derives empty and
// occupancy from it. It owns the read pointer (binary and Gray) and drives
// the memory read address. Data is presented through a first-word-fall-through
// output register with a valid/ready handshake.
module fifo_rd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_ptr_g,
  output logic [ADDR_W:0]   rd_ptr_g,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              err
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ADDR_W);

  // The output register is either empty (IDLE) or holding a word (FULL).
  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]     wq_g;
  logic [PW-1:0]     wq_b;
  logic [PW-1:0]     rd_ptr_b_q, rd_ptr_b_d;
  logic [PW-1:0]     rd_ptr_g_q, rd_ptr_g_d;
  logic [PW-1:0]     next_bin;
  logic [DATA_W-1:0] dout_q, dout_d;
  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              empty_c;
  logic              overrun;
  logic              pop;
  logic [PW-1:0]     level_c;

  // Plain shift chain for the incoming Gray pointer; nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_g};
  end

  assign wq_g = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wq_b         = '0;
    wq_b[ADDR_W] = wq_g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      wq_b[i] = wq_b[i+1] ^ wq_g[i];
    end
  end

  // Occupancy, empty/overrun detection and the pop decision.
  always_comb begin
    level_c = wq_b - rd_ptr_b_q;
    empty_c = (wq_b == rd_ptr_b_q);
    // A gap beyond DEPTH can only come from an overrun or a corrupted
    // pointer, so reading is frozen while it lasts.
    overrun = (level_c > DEPTH_P);
    pop     = !empty_c && !overrun && ((state_q == S_IDLE) || dout_ready);
  end

  // Next state for pointers, output register, handshake FSM and error flag.
  always_comb begin
    next_bin   = rd_ptr_b_q + PW'(1);
    rd_ptr_b_d = rd_ptr_b_q;
    rd_ptr_g_d = rd_ptr_g_q;
    dout_d     = dout_q;
    state_d    = state_q;
    err_d      = err_q | overrun;
    if (pop) begin
      rd_ptr_b_d = next_bin;
      // Gray is registered from the incremented binary so the value sent to
      // the write domain changes one bit per step and never glitches.
      rd_ptr_g_d = next_bin ^ (next_bin >> 1);
      dout_d     = mem_rdata;
      state_d    = S_FULL;
    end else if ((state_q == S_FULL) && dout_ready) begin
      state_d = S_IDLE;
    end
  end

  // State registers; reset discards any word held in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_b_q <= '0;
      rd_ptr_g_q <= '0;
      dout_q     <= '0;
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_b_q <= rd_ptr_b_d;
      rd_ptr_g_q <= rd_ptr_g_d;
      dout_q     <= dout_d;
      state_q    <= state_d;
      err_q      <= err_d;
    end
  end

  assign rd_ptr_g   = rd_ptr_g_q;
  assign mem_raddr  = rd_ptr_b_q[ADDR_W-1:0];
  assign dout       = dout_q;
  assign dout_valid = (state_q == S_FULL);
  assign empty      = empty_c;
  assign rd_level   = level_c;
  assign err        = err_q;

endmodule
